// File: rtl/fm_vout_timing_pkg.sv
// Shared types and timing presets for the fm_hdmi video timing generator.
// Presets describe one display mode each; the top takes its defaults from the VGA preset.
package fm_vout_timing_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          hs_pol;
    bit          vs_pol;
  } timing_t;

  // 640x480@60, active-low syncs
  localparam timing_t TIMING_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  // 1280x720@60, active-high syncs
  localparam timing_t TIMING_1280X720 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/fm_vout_tcnt.sv
// Wrapping timing counter with active and sync window decodes.
// Used once per axis; the decodes are combinational from the count register.
module fm_vout_tcnt #(
  parameter int P_CW       = 12,
  parameter int P_TOTAL    = 800,
  parameter int P_ACT      = 640,
  parameter int P_SYNC_BEG = 656,
  parameter int P_SYNC_END = 752
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_inc,
  output logic [P_CW-1:0] o_cnt,
  output logic            o_wrap,
  output logic            o_active,
  output logic            o_sync
);

  localparam logic [P_CW-1:0] LAST     = P_CW'(P_TOTAL - 1);
  localparam logic [P_CW-1:0] ACT      = P_CW'(P_ACT);
  localparam logic [P_CW-1:0] SYNC_BEG = P_CW'(P_SYNC_BEG);
  localparam logic [P_CW-1:0] SYNC_END = P_CW'(P_SYNC_END);

  logic [P_CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst || i_clear) begin
      cnt_q <= '0;
    end else if (i_inc) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + P_CW'(1);
    end
  end

  assign o_cnt    = cnt_q;
  assign o_wrap   = (cnt_q == LAST);
  assign o_active = (cnt_q < ACT);
  assign o_sync   = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);

endmodule

// File: rtl/fm_vout_timing.sv
// Video timing generator: registered syncs, data enable and active-pixel coordinates.
// Starts and stops only on frame boundaries so the downstream delay line never sees a partial frame.
module fm_vout_timing
  import fm_vout_timing_pkg::*;
#(
  parameter int P_H_ACTIVE = TIMING_640X480.h_active,
  parameter int P_H_FP     = TIMING_640X480.h_fp,
  parameter int P_H_SYNC   = TIMING_640X480.h_sync,
  parameter int P_H_BP     = TIMING_640X480.h_bp,
  parameter int P_V_ACTIVE = TIMING_640X480.v_active,
  parameter int P_V_FP     = TIMING_640X480.v_fp,
  parameter int P_V_SYNC   = TIMING_640X480.v_sync,
  parameter int P_V_BP     = TIMING_640X480.v_bp,
  parameter bit P_HS_POL   = TIMING_640X480.hs_pol,
  parameter bit P_VS_POL   = TIMING_640X480.vs_pol,
  parameter int P_CW       = 12
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            i_enable,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic [P_CW-1:0] o_x,
  output logic [P_CW-1:0] o_y,
  output logic            o_frame_start,
  output logic            o_line_start,
  output logic            o_busy
);

  localparam int H_TOTAL = line_total(P_H_ACTIVE, P_H_FP, P_H_SYNC, P_H_BP);
  localparam int V_TOTAL = line_total(P_V_ACTIVE, P_V_FP, P_V_SYNC, P_V_BP);

  state_t state_q, state_d;
  logic   stop_q, stop_d;
  logic   run;

  logic [P_CW-1:0] h_cnt, v_cnt;
  logic            h_wrap, h_act, h_sync;
  logic            v_wrap, v_act, v_sync;
  logic            frame_end;
  logic            de_d;

  assign run       = (state_q == ST_RUN);
  assign frame_end = h_wrap && v_wrap;

  // Counters are held at zero while idle, so entering RUN always begins at (0,0).
  fm_vout_tcnt #(
    .P_CW      (P_CW),
    .P_TOTAL   (H_TOTAL),
    .P_ACT     (P_H_ACTIVE),
    .P_SYNC_BEG(P_H_ACTIVE + P_H_FP),
    .P_SYNC_END(P_H_ACTIVE + P_H_FP + P_H_SYNC)
  ) u_hcnt (
    .clk_sys (clk_sys),
    .rst     (rst),
    .i_clear (!run),
    .i_inc   (run),
    .o_cnt   (h_cnt),
    .o_wrap  (h_wrap),
    .o_active(h_act),
    .o_sync  (h_sync)
  );

  fm_vout_tcnt #(
    .P_CW      (P_CW),
    .P_TOTAL   (V_TOTAL),
    .P_ACT     (P_V_ACTIVE),
    .P_SYNC_BEG(P_V_ACTIVE + P_V_FP),
    .P_SYNC_END(P_V_ACTIVE + P_V_FP + P_V_SYNC)
  ) u_vcnt (
    .clk_sys (clk_sys),
    .rst     (rst),
    .i_clear (!run),
    .i_inc   (run && h_wrap),
    .o_cnt   (v_cnt),
    .o_wrap  (v_wrap),
    .o_active(v_act),
    .o_sync  (v_sync)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        stop_d = !i_enable;
        if (frame_end && (stop_q || !i_enable)) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end
    endcase
  end

  assign de_d = run && h_act && v_act;

  // Output stage: one register per signal, reflecting the counter state of the previous cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      o_hsync       <= ~P_HS_POL;
      o_vsync       <= ~P_VS_POL;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
    end else begin
      o_hsync       <= (run && h_sync) ? P_HS_POL : ~P_HS_POL;
      o_vsync       <= (run && v_sync) ? P_VS_POL : ~P_VS_POL;
      o_de          <= de_d;
      o_x           <= de_d ? h_cnt : '0;
      o_y           <= de_d ? v_cnt : '0;
      o_frame_start <= de_d && (h_cnt == '0) && (v_cnt == '0);
      o_line_start  <= de_d && (h_cnt == '0);
    end
  end

  assign o_busy = run;

endmodule

// File: tb/tb_fm_vout_timing.sv
// Self-checking bench for fm_vout_timing on a 16x8 total raster (8x4 active).
// A frame-position model predicts every output each cycle; directed phases add literal checks.
module tb_fm_vout_timing;

  localparam int CW  = 12;
  localparam int HT  = 16;
  localparam int VT  = 8;
  localparam int FRM = HT * VT;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          i_enable = 1'b0;
  logic          o_hsync, o_vsync, o_de, o_frame_start, o_line_start, o_busy;
  logic [CW-1:0] o_x, o_y;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  fm_vout_timing #(
    .P_H_ACTIVE(8), .P_H_FP(2), .P_H_SYNC(3), .P_H_BP(3),
    .P_V_ACTIVE(4), .P_V_FP(1), .P_V_SYNC(2), .P_V_BP(1),
    .P_HS_POL(1'b0), .P_VS_POL(1'b0), .P_CW(CW)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .i_enable     (i_enable),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_de         (o_de),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_frame_start(o_frame_start),
    .o_line_start (o_line_start),
    .o_busy       (o_busy)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a running flag and a position 0..FRM-1 within the frame; outputs follow from
  // h = pos % HT, v = pos / HT and the window rules, one cycle late.
  bit m_valid = 0, m_run = 0, m_stop = 0;
  int m_pos = 0;
  logic e_hs, e_vs, e_de, e_fs, e_ls, e_busy;
  int e_x, e_y;

  always @(posedge clk_sys) begin
    int h, v;
    h = m_pos % HT;
    v = m_pos / HT;
    if (rst) begin
      {e_de, e_fs, e_ls} = 3'b000;
      e_hs = 1'b1; e_vs = 1'b1; e_x = 0; e_y = 0;
      m_run = 0; m_pos = 0; m_stop = 0;
    end else begin
      e_de = m_run && h < 8 && v < 4;
      e_hs = !(m_run && h >= 10 && h < 13);
      e_vs = !(m_run && v >= 5 && v < 7);
      e_x  = e_de ? h : 0;
      e_y  = e_de ? v : 0;
      e_fs = e_de && m_pos == 0;
      e_ls = e_de && h == 0;
      if (!m_run) begin
        if (i_enable) begin m_run = 1; m_pos = 0; end
      end else if (m_pos == FRM - 1) begin
        if (m_stop || !i_enable) m_run = 0;
        m_pos = 0; m_stop = 0;
      end else begin
        m_pos++;
        m_stop = !i_enable;
      end
    end
    e_busy = m_run;
    m_valid = 1;
  end

  always @(negedge clk_sys) begin
    if (m_valid) begin
      vectors++;
      if ({o_hsync, o_vsync, o_de, o_frame_start, o_line_start, o_busy} !==
            {e_hs, e_vs, e_de, e_fs, e_ls, e_busy} || int'(o_x) != e_x || int'(o_y) != e_y) begin
        fails++;
        $display("FAIL model cycle %0d: got hs=%b vs=%b de=%b fs=%b ls=%b busy=%b x=%0d y=%0d expected hs=%b vs=%b de=%b fs=%b ls=%b busy=%b x=%0d y=%0d",
                 cyc, o_hsync, o_vsync, o_de, o_frame_start, o_line_start, o_busy, o_x, o_y,
                 e_hs, e_vs, e_de, e_fs, e_ls, e_busy, e_x, e_y);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_fs(input string name, output int stamp);
    stamp = -1;
    for (int i = 0; i < 300; i++) begin
      if (o_frame_start === 1'b1) begin stamp = cyc; break; end
      step(1);
    end
    if (stamp < 0) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_line(input string name, input int y);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (o_line_start === 1'b1 && int'(o_y) == y) begin seen = 1; break; end
      step(1);
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n_de, n_hs, n_vs, n_ls, n_blank, first_hs, first_vs, t0, t1;

    // Reset and start
    step(3);
    check("rst_busy", o_busy, 0);
    check("rst_hsync", o_hsync, 1);
    check("rst_vsync", o_vsync, 1);
    rst = 1'b0;
    step(2);
    check("idle_de", o_de, 0);
    check("idle_busy", o_busy, 0);
    i_enable = 1'b1;
    step(1);
    check("start_busy_n1", o_busy, 1);
    check("start_de_n1", o_de, 0);
    step(1);
    check("start_fs_n2", o_frame_start, 1);
    check("start_de_n2", o_de, 1);

    // One full frame measured from the first frame_start
    n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_blank = 0; first_hs = -1; first_vs = -1;
    for (int k = 0; k < FRM; k++) begin
      if (k < 8) check("line0_x", o_x, k);
      if (o_de) n_de++;
      if (!o_hsync) begin n_hs++; if (first_hs < 0) first_hs = k; end
      if (!o_vsync) begin n_vs++; if (first_vs < 0) first_vs = k; end
      if (o_line_start) begin check("ls_y", o_y, n_ls); check("ls_x", o_x, 0); n_ls++; end
      if (!o_de && (o_x != 0 || o_y != 0)) n_blank++;
      step(1);
    end
    check("frame_de_cycles", n_de, 32);
    check("frame_hs_low", n_hs, 24);
    check("frame_vs_low", n_vs, 32);
    check("first_hs_offset", first_hs, 10);
    check("first_vs_offset", first_vs, 80);
    check("line_starts", n_ls, 4);
    check("blank_coords", n_blank, 0);
    check("frame_period", o_frame_start, 1);

    // Graceful stop: drop enable at line 2, frame completes, then idle
    n_de = 0;
    for (int i = 0; i < 220; i++) begin
      if (o_de) n_de++;
      if (o_line_start && o_y == 2) i_enable = 1'b0;
      step(1);
    end
    check("stop_de_cycles", n_de, 32);
    check("stop_busy", o_busy, 0);
    check("stop_hsync", o_hsync, 1);
    check("stop_vsync", o_vsync, 1);

    // Cancelled stop: low at line 1, high again at line 6
    i_enable = 1'b1;
    wait_fs("cancel_fs0", t0);
    wait_line("cancel_l1", 1);
    i_enable = 1'b0;
    step(80);
    i_enable = 1'b1;
    wait_fs("cancel_fs1", t1);
    check("cancel_period", t1 - t0, FRM);

    // Reset mid-frame during active line 2
    wait_line("rst_l2", 2);
    step(3);
    rst = 1'b1;
    step(1);
    check("midrst_de", o_de, 0);
    check("midrst_x", o_x, 0);
    check("midrst_y", o_y, 0);
    check("midrst_hsync", o_hsync, 1);
    check("midrst_vsync", o_vsync, 1);
    check("midrst_busy", o_busy, 0);
    rst = 1'b0;
    step(1);
    check("restart_busy", o_busy, 1);
    step(1);
    check("restart_fs", o_frame_start, 1);
    check("restart_xy", {o_x, o_y}, 0);
    step(20);
    i_enable = 1'b0;
    step(150);
    check("final_busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fm_vout_timing.md
Name: fm_vout_timing

Overview:
- Video timing generator for the fm_hdmi output path.
- Produces registered hsync, vsync, data-enable and pixel coordinates from programmable-by-parameter horizontal/vertical counters.
- Sits directly upstream of the vout delay line, which realigns these control signals with pixel data fetched using o_x/o_y.
- Supports clean start/stop on frame boundaries only.

Parameters:
- P_H_ACTIVE, 640, active pixels per line
- P_H_FP, 16, horizontal front porch (clocks)
- P_H_SYNC, 96, hsync width (clocks)
- P_H_BP, 48, horizontal back porch (clocks)
- P_V_ACTIVE, 480, active lines per frame
- P_V_FP, 10, vertical front porch (lines)
- P_V_SYNC, 2, vsync width (lines)
- P_V_BP, 33, vertical back porch (lines)
- P_HS_POL, 0, hsync asserted level (0 = active-low)
- P_VS_POL, 0, vsync asserted level
- P_CW, 12, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_sys input 1: pixel/system clock
- rst input 1: synchronous, active-high reset
- i_enable input 1: run request, level-sensitive
- o_hsync output 1: horizontal sync, level per P_HS_POL
- o_vsync output 1: vertical sync, level per P_VS_POL
- o_de output 1: active-video data enable
- o_x output P_CW: active pixel column, 0 outside active video
- o_y output P_CW: active line, 0 outside active video
- o_frame_start output 1: one-cycle pulse coincident with o_de at pixel (0,0)
- o_line_start output 1: one-cycle pulse coincident with o_de at x=0 of every active line
- o_busy output 1: high in RUN state

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent.
- Counter h runs 0..H_TOTAL-1 and wraps to 0. Counter v increments when h wraps, 0..V_TOTAL-1, then wraps to 0.
- Line order: active (h < H_ACTIVE), then FP, then SYNC, then BP. Vertical order is the same, in lines.
- hsync asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync changes only at h=0 boundaries.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- All outputs are registered; outputs for counter state (h,v) appear one cycle after the counter holds (h,v).
- Reset (synchronous, dominant over everything):
  - state IDLE; h=v=0; stop_pending=0
  - o_hsync=~P_HS_POL, o_vsync=~P_VS_POL
  - o_de=0, o_x=o_y=0, o_frame_start=o_line_start=0, o_busy=0
- States:
  - IDLE: counters held at 0; outputs at reset values. i_enable sampled high at cycle N moves to RUN at N+1 with h=v=0. First o_de/o_frame_start appears at N+2.
  - RUN: counters advance every cycle; o_busy=1.
    - i_enable sampled low sets stop_pending.
    - i_enable sampled high clears stop_pending, so a re-enable before frame end cancels the stop.
    - At h=H_TOTAL-1 and v=V_TOTAL-1 with stop_pending (or i_enable low that cycle): go to IDLE, counters to 0, stop_pending cleared. Otherwise wrap and continue.
- Frames are never truncated. Once RUN is entered, at least one full frame is emitted.
- Reset mid-frame aborts immediately. Outputs return to inactive levels on the cycle after reset is sampled.
- o_line_start and o_frame_start are never asserted without o_de.

Decomposition:
- Package fm_vout_timing_pkg holds:
  - state encoding (IDLE, RUN)
  - timing presets as constants: 640x480@60 (defaults), 1280x720@60 (1280/110/40/220, 720/5/5/20, positive polarity)
- One sub-module, fm_vout_tcnt: a wrapping counter with P_TOTAL, increment-enable, a wrap flag, and two window compares (active, sync). Instantiate it twice, for h and v.

Test Plan:
Small config for all tests: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), active-low syncs.
- Start: rst high 3 cycles, then i_enable=1 sampled at cycle N -> o_frame_start=1 and o_de=1 with x=0,y=0 at N+2; de runs 8 cycles with x=0..7; o_busy=1 from N+1.
- Sync timing: in each line, o_hsync is low for exactly 3 cycles beginning 10 cycles after de rises; o_vsync is low for 32 cycles (lines 5-6); frame period is 128 cycles.
- Graceful stop: drop i_enable mid-line 2 -> remaining lines complete; the last frame has 32 de-cycles; IDLE follows; no further o_de; syncs held inactive.
- Cancelled stop: i_enable low at line 1, high again at line 6 -> no gap; the next o_frame_start arrives exactly 128 cycles after the previous one.
- Reset mid-frame: assert rst during active line 2 -> next cycle o_de=0, o_x=o_y=0, syncs inactive, o_busy=0; after re-enable, the frame restarts at (0,0).
- Coordinates: check o_line_start on every x=0 of lines 0-3, and that o_x/o_y read 0 in all blanking cycles.
